vga_mem_arbiter: RTL and testbench

Four-port arbiter and sequencer for the single-port frame memory (`vgaMemory`) shared by the camera writer, line-buffer loader, convolution write-back and HPS image readout. It replaces the ad-hoc address/data/write-enable muxing around the memory with registered one-hot grants, per-requester locks and read-data routing. It sits between those four masters and the memory's address, data, write-enable and read ports.

---
 rtl/vga_mem_arbiter.sv | 132 +++++++++++++
 tb/tb_vga_mem_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/vga_mem_arbiter.sv
// Four-port arbiter and sequencer for the shared single-port frame memory.
// Define ARB_ROUND_ROBIN_EN to rotate BUF/CONV/HPS priority; CAM always stays highest.
module vga_mem_arbiter #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        req,
  input  logic [3:0]        lock,
  input  logic [3:0]        we,
  input  logic [4*AW-1:0]   addr_in,
  input  logic [4*DW-1:0]   wdata_in,
  output logic [3:0]        gnt,
  output logic [3:0]        rd_valid,
  output logic [DW-1:0]     rd_data,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  output logic              mem_we,
  input  logic [DW-1:0]     mem_rdata,
  output logic              busy
);

  localparam int unsigned NREQ = 4;

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_LOCKED} state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] rd_valid_q, rd_valid_d;
  logic [AW-1:0]   addr_hold_q, addr_hold_d;
  logic [1:0]      win_idx;
  logic            win_any;
  logic            keep;

  // Owner keeps a locked burst unless CAM asks for the bus.
  assign keep    = (|(gnt_q & req & lock)) && !(req[0] && !gnt_q[0]);
  assign win_any = |req;

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0] rr_q, rr_d;
  logic [2:0] cand;
  logic       found;

  // CAM first, then scan BUF..HPS starting at the pointer.
  always_comb begin
    win_idx = 2'd0;
    cand    = 3'd0;
    found   = 1'b0;
    if (req[0]) begin
      found = 1'b1;
    end else begin
      for (int k = 0; k < 3; k++) begin
        cand = {1'b0, rr_q} + 3'(k);
        if (cand > 3'd3) cand = cand - 3'd3;
        if (!found && req[cand[1:0]]) begin
          found   = 1'b1;
          win_idx = cand[1:0];
        end
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (!keep && win_any && (win_idx != 2'd0)) begin
      rr_d = (win_idx == 2'd3) ? 2'd1 : (win_idx + 2'd1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rr_q <= 2'd1;
    else       rr_q <= rr_d;
  end
`else
  always_comb begin
    win_idx = 2'd0;
    if      (req[0]) win_idx = 2'd0;
    else if (req[1]) win_idx = 2'd1;
    else if (req[2]) win_idx = 2'd2;
    else if (req[3]) win_idx = 2'd3;
  end
`endif

  // Memory port mux: only a granted, still-requesting master touches memory.
  always_comb begin
    mem_addr  = addr_hold_q;
    mem_wdata = '0;
    mem_we    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q[i] && req[i]) begin
        mem_addr  = addr_in[i*AW +: AW];
        mem_wdata = wdata_in[i*DW +: DW];
        mem_we    = we[i];
      end
    end
  end

  always_comb begin
    state_d     = ST_IDLE;
    gnt_d       = '0;
    rd_valid_d  = gnt_q & req & ~we;
    addr_hold_d = mem_addr;
    if (keep) begin
      state_d = ST_LOCKED;
      gnt_d   = gnt_q;
    end else if (win_any) begin
      state_d = ST_GRANT;
      gnt_d   = NREQ'(1'b1) << win_idx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      rd_valid_q  <= '0;
      addr_hold_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rd_valid_q  <= rd_valid_d;
      addr_hold_q <= addr_hold_d;
    end
  end

  assign gnt      = gnt_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = mem_rdata;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Directed table-driven bench for vga_mem_arbiter plus a hand-written async reset sequence.
module tb_vga_mem_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic [3:0]     req, lock, we;
  logic [4*AW-1:0] addr_in;
  logic [4*DW-1:0] wdata_in;
  logic [3:0]     gnt, rd_valid;
  logic [DW-1:0]  rd_data, mem_wdata;
  logic [DW-1:0]  mem_rdata = '0;
  logic [AW-1:0]  mem_addr;
  logic           mem_we, busy;

  int n_vec  = 0;
  int n_miss = 0;

  vga_mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .we(we),
    .addr_in(addr_in), .wdata_in(wdata_in), .gnt(gnt), .rd_valid(rd_valid),
    .rd_data(rd_data), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory stand-in: read data is a recognisable function of last cycle's address.
  always @(posedge clk) mem_rdata <= {16'hA5A5, mem_addr};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
    $fatal(1);
  end

  typedef struct {
    logic [3:0]  req, lock, we;
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  e_gnt, e_rv;
    logic        e_we;
    logic [15:0] e_addr;
    logic [31:0] e_wdata, e_rd;
    logic        e_busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [3:0] r, logic [3:0] l, logic [3:0] w,
                              logic [15:0] a, logic [31:0] d,
                              logic [3:0] eg, logic [3:0] ev, logic ew,
                              logic [15:0] ea, logic [31:0] ed, logic [31:0] er,
                              logic eb);
    vec_t v;
    v.req = r; v.lock = l; v.we = w; v.addr = a; v.data = d;
    v.e_gnt = eg; v.e_rv = ev; v.e_we = ew; v.e_addr = ea;
    v.e_wdata = ed; v.e_rd = er; v.e_busy = eb;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s vec %0d: got %h want %h", name, idx, act, exp);
    end
  endtask

  // Requester i sees addr ^ (i<<12) and data ^ i, so mux index faults are visible.
  task automatic drive(input logic [3:0] r, input logic [3:0] l, input logic [3:0] w,
                       input logic [15:0] a, input logic [31:0] d);
    req = r; lock = l; we = w;
    for (int i = 0; i < 4; i++) begin
      addr_in[i*AW +: AW]  = a ^ (16'(i) << 12);
      wdata_in[i*DW +: DW] = d ^ 32'(i);
    end
  endtask

  task automatic check_outs(input int idx, input logic [3:0] eg, input logic [3:0] ev,
                            input logic ew, input logic [15:0] ea, input logic eb);
    n_vec++;
    chk("gnt", idx, 32'(gnt), 32'(eg));
    chk("rd_valid", idx, 32'(rd_valid), 32'(ev));
    chk("mem_we", idx, 32'(mem_we), 32'(ew));
    chk("mem_addr", idx, 32'(mem_addr), 32'(ea));
    chk("busy", idx, 32'(busy), 32'(eb));
  endtask

`ifdef ARB_ROUND_ROBIN_EN
  localparam logic [15:0] P_HOLD = 16'h3000;
`else
  localparam logic [15:0] P_HOLD = 16'h1000;
`endif

  initial begin
    // Priority from reset.
    tbl.push_back(mk(4'h0, 4'h0, 4'h0, 16'h0000, 32'h0, 4'h0, 4'h0, 1'b0, 16'h0000, 32'h0, 32'h0, 1'b0));
    tbl.push_back(mk(4'hE, 4'h0, 4'h0, 16'h0000, 32'h0, 4'h0, 4'h0, 1'b0, 16'h0000, 32'h0, 32'h0, 1'b0));
    tbl.push_back(mk(4'hE, 4'h0, 4'h0, 16'h0000, 32'h0, 4'h2, 4'h0, 1'b0, 16'h1000, 32'h0, 32'h0, 1'b1));
`ifdef ARB_ROUND_ROBIN_EN
    tbl.push_back(mk(4'hE, 4'h0, 4'h0, 16'h0000, 32'h0, 4'h4, 4'h2, 1'b0, 16'h2000, 32'h0, 32'hA5A51000, 1'b1));
    tbl.push_back(mk(4'hE, 4'h0, 4'h0, 16'h0000, 32'h0, 4'h8, 4'h4, 1'b0, 16'h3000, 32'h0, 32'hA5A52000, 1'b1));
    tbl.push_back(mk(4'h0, 4'h0, 4'h0, 16'h0000, 32'h0, 4'h2, 4'h8, 1'b0, 16'h3000, 32'h0, 32'hA5A53000, 1'b1));
`else
    tbl.push_back(mk(4'hE, 4'h0, 4'h0, 16'h0000, 32'h0, 4'h2, 4'h2, 1'b0, 16'h1000, 32'h0, 32'hA5A51000, 1'b1));
    tbl.push_back(mk(4'hE, 4'h0, 4'h0, 16'h0000, 32'h0, 4'h2, 4'h2, 1'b0, 16'h1000, 32'h0, 32'hA5A51000, 1'b1));
    tbl.push_back(mk(4'h0, 4'h0, 4'h0, 16'h0000, 32'h0, 4'h2, 4'h2, 1'b0, 16'h1000, 32'h0, 32'hA5A51000, 1'b1));
`endif
    tbl.push_back(mk(4'h0, 4'h0, 4'h0, 16'h0000, 32'h0, 4'h0, 4'h0, 1'b0, P_HOLD, 32'h0, 32'h0, 1'b0));
    // Single BUF read of 0x0123.
    tbl.push_back(mk(4'h2, 4'h0, 4'h0, 16'h1123, 32'h0, 4'h0, 4'h0, 1'b0, P_HOLD, 32'h0, 32'h0, 1'b0));
    tbl.push_back(mk(4'h2, 4'h0, 4'h0, 16'h1123, 32'h0, 4'h2, 4'h0, 1'b0, 16'h0123, 32'h0, 32'h0, 1'b1));
    tbl.push_back(mk(4'h0, 4'h0, 4'h0, 16'h1123, 32'h0, 4'h2, 4'h2, 1'b0, 16'h0123, 32'h0, 32'hA5A50123, 1'b1));
    tbl.push_back(mk(4'h0, 4'h0, 4'h0, 16'h1123, 32'h0, 4'h0, 4'h0, 1'b0, 16'h0123, 32'h0, 32'h0, 1'b0));
    // CAM write to the top address.
    tbl.push_back(mk(4'h1, 4'h0, 4'h1, 16'hFFFF, 32'hAA, 4'h0, 4'h0, 1'b0, 16'h0123, 32'h0, 32'h0, 1'b0));
    tbl.push_back(mk(4'h1, 4'h0, 4'h1, 16'hFFFF, 32'hAA, 4'h1, 4'h0, 1'b1, 16'hFFFF, 32'hAA, 32'h0, 1'b1));
    tbl.push_back(mk(4'h0, 4'h0, 4'h0, 16'hFFFF, 32'hAA, 4'h1, 4'h0, 1'b0, 16'hFFFF, 32'h0, 32'h0, 1'b1));
    tbl.push_back(mk(4'h0, 4'h0, 4'h0, 16'hFFFF, 32'hAA, 4'h0, 4'h0, 1'b0, 16'hFFFF, 32'h0, 32'h0, 1'b0));
    // CONV locked burst, preempted by CAM on the third beat.
    tbl.push_back(mk(4'h4, 4'h4, 4'h4, 16'h2040, 32'hDEADBEED, 4'h0, 4'h0, 1'b0, 16'hFFFF, 32'h0, 32'h0, 1'b0));
    tbl.push_back(mk(4'h4, 4'h4, 4'h4, 16'h2040, 32'hDEADBEED, 4'h4, 4'h0, 1'b1, 16'h0040, 32'hDEADBEEF, 32'h0, 1'b1));
    tbl.push_back(mk(4'h4, 4'h4, 4'h4, 16'h2041, 32'hDEADBEED, 4'h4, 4'h0, 1'b1, 16'h0041, 32'hDEADBEEF, 32'h0, 1'b1));
    tbl.push_back(mk(4'h5, 4'h4, 4'h4, 16'h2042, 32'hDEADBEED, 4'h4, 4'h0, 1'b1, 16'h0042, 32'hDEADBEEF, 32'h0, 1'b1));
    tbl.push_back(mk(4'h5, 4'h4, 4'h4, 16'h2043, 32'hDEADBEED, 4'h1, 4'h0, 1'b0, 16'h2043, 32'h0, 32'h0, 1'b1));
    tbl.push_back(mk(4'h4, 4'h4, 4'h4, 16'h2043, 32'hDEADBEED, 4'h1, 4'h1, 1'b0, 16'h2043, 32'h0, 32'hA5A52043, 1'b1));
    tbl.push_back(mk(4'h4, 4'h4, 4'h4, 16'h2043, 32'hDEADBEED, 4'h4, 4'h0, 1'b1, 16'h0043, 32'hDEADBEEF, 32'h0, 1'b1));
    tbl.push_back(mk(4'h0, 4'h0, 4'h0, 16'h2043, 32'hDEADBEED, 4'h4, 4'h0, 1'b0, 16'h0043, 32'h0, 32'h0, 1'b1));
    tbl.push_back(mk(4'h0, 4'h0, 4'h0, 16'h2043, 32'hDEADBEED, 4'h0, 4'h0, 1'b0, 16'h0043, 32'h0, 32'h0, 1'b0));

    reset = 1'b1;
    drive(4'h0, 4'h0, 4'h0, 16'h0000, 32'h0);
    @(negedge clk);
    @(negedge clk);
    #1 check_outs(-1, 4'h0, 4'h0, 1'b0, 16'h0000, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].req, tbl[i].lock, tbl[i].we, tbl[i].addr, tbl[i].data);
      #1;
      check_outs(i, tbl[i].e_gnt, tbl[i].e_rv, tbl[i].e_we, tbl[i].e_addr, tbl[i].e_busy);
      if (tbl[i].e_we) chk("mem_wdata", i, mem_wdata, tbl[i].e_wdata);
      if (tbl[i].e_rv != 4'h0) chk("rd_data", i, rd_data, tbl[i].e_rd);
    end

    // HPS locked read burst, then asynchronous reset between clock edges.
    @(negedge clk);
    drive(4'h8, 4'h8, 4'h0, 16'h3010, 32'h0);
    @(negedge clk);
    #1 check_outs(100, 4'h8, 4'h0, 1'b0, 16'h0010, 1'b1);
    @(posedge clk);
    #2 check_outs(101, 4'h8, 4'h8, 1'b0, 16'h0010, 1'b1);
    chk("rd_data", 101, rd_data, 32'hA5A50010);
    #1 reset = 1'b1;
    #1 check_outs(102, 4'h0, 4'h0, 1'b0, 16'h0000, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    drive(4'h9, 4'h8, 4'h0, 16'h3010, 32'h0);
    #1 check_outs(103, 4'h0, 4'h0, 1'b0, 16'h0000, 1'b0);
    @(posedge clk);
    #1 check_outs(104, 4'h1, 4'h0, 1'b0, 16'h3010, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
